// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//  Shared pipeline definitions for the fetch/decode boundary.
//  - NOP_INSTR : bubble encoding (addi x0,x0,0)
//  - PC_INC    : sequential fetch increment
//  - if_id_t   : contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_INC    = 32'h0000_0004;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_four;
      logic [31:0] instr;
      logic        insn_vld;
   } if_id_t;

endpackage

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//  Fetch PC register with redirect/stall selection and +4 incrementer.
//  Optional feature macro: IF_STAGE_MISALIGN_CHK_EN (word-aligns redirect
//  targets before they reach the PC register).
//  Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_stall         hold the PC
//   i_redirect      load i_redirect_pc (beats i_stall)
//   i_redirect_pc   redirect target
//   o_pc            current fetch PC (register output, no logic in path)
//   o_pc_plus4      o_pc + 4, modulo 2^32
// -----------------------------------------------------------------------------
module pc_gen
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] target_s;

`ifdef IF_STAGE_MISALIGN_CHK_EN
   // Misaligned targets are forced onto a word boundary; the flag lives in if_stage.
   assign target_s = {i_redirect_pc[31:2], 2'b00};
`else
   assign target_s = i_redirect_pc;
`endif

   assign o_pc       = pc_q;
   assign o_pc_plus4 = pc_q + PC_INC;

   // Next-PC selection: redirect, then stall, then sequential.
   always_comb begin
      pc_d = pc_q;
      if (i_redirect) begin
         pc_d = target_s;
      end else if (i_stall) begin
         pc_d = pc_q;
      end else begin
         pc_d = o_pc_plus4;
      end
   end

   // Fetch PC register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//  Instruction-fetch stage plus IF/ID pipeline register.
//  Optional feature macro: IF_STAGE_MISALIGN_CHK_EN (adds o_misalign_D).
//  Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_stall          hold fetch PC and IF/ID contents
//   i_flush          load a bubble into IF/ID
//   i_redirect       taken branch/jump from EX (also bubbles IF/ID)
//   i_redirect_pc    redirect target
//   i_instr          instruction read combinationally at o_imem_addr
//   o_imem_addr      fetch PC
//   o_pc_D, o_pc_four_D, o_instr_D, o_insn_vld_D   decode-side IF/ID fields
//   o_misalign_D     (macro only) decode instruction came from a misaligned redirect
// -----------------------------------------------------------------------------
module if_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic [31:0] i_instr,
`ifdef IF_STAGE_MISALIGN_CHK_EN
   output logic        o_misalign_D,
`endif
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_pc_D,
   output logic [31:0] o_pc_four_D,
   output logic [31:0] o_instr_D,
   output logic        o_insn_vld_D
);

   logic [31:0] pc_f_s;
   logic [31:0] pc_f_plus4_s;
   if_id_t      if_id_q;
   if_id_t      if_id_d;
   logic        load_vld_s;

   pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_pc          (pc_f_s),
      .o_pc_plus4    (pc_f_plus4_s)
   );

   assign o_imem_addr  = pc_f_s;
   assign o_pc_D       = if_id_q.pc;
   assign o_pc_four_D  = if_id_q.pc_four;
   assign o_instr_D    = if_id_q.instr;
   assign o_insn_vld_D = if_id_q.insn_vld;

`ifdef IF_STAGE_MISALIGN_CHK_EN
   logic sticky_q;
   logic sticky_d;
   logic misalign_q;
   logic misalign_d;

   // The instruction fetched from a misaligned target is delivered as invalid.
   assign load_vld_s   = ~sticky_q;
   assign o_misalign_D = misalign_q;

   // Sticky flag is armed by a misaligned redirect and consumed by the next IF/ID load.
   // Redirect takes precedence over flush so the hazard unit's companion flush does not clear it.
   always_comb begin
      sticky_d   = sticky_q;
      misalign_d = misalign_q;
      if (i_redirect) begin
         sticky_d   = (i_redirect_pc[1:0] != 2'b00);
         misalign_d = 1'b0;
      end else if (i_flush) begin
         sticky_d   = 1'b0;
         misalign_d = 1'b0;
      end else if (i_stall) begin
         sticky_d   = sticky_q;
         misalign_d = misalign_q;
      end else begin
         sticky_d   = 1'b0;
         misalign_d = sticky_q;
      end
   end

   // Misalign flag registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sticky_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         sticky_q   <= sticky_d;
         misalign_q <= misalign_d;
      end
   end
`else
   assign load_vld_s = 1'b1;
`endif

   // IF/ID next value: bubble on redirect/flush, hold on stall, otherwise capture fetch.
   always_comb begin
      if_id_d = if_id_q;
      if (i_redirect || i_flush) begin
         if_id_d.pc       = 32'h0000_0000;
         if_id_d.pc_four  = 32'h0000_0000;
         if_id_d.instr    = NOP_INSTR;
         if_id_d.insn_vld = 1'b0;
      end else if (i_stall) begin
         if_id_d = if_id_q;
      end else begin
         if_id_d.pc       = pc_f_s;
         if_id_d.pc_four  = pc_f_plus4_s;
         if_id_d.instr    = i_instr;
         if_id_d.insn_vld = load_vld_s;
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         if_id_q.pc       <= 32'h0000_0000;
         if_id_q.pc_four  <= 32'h0000_0000;
         if_id_q.instr    <= NOP_INSTR;
         if_id_q.insn_vld <= 1'b0;
      end else begin
         if_id_q <= if_id_d;
      end
   end

endmodule
